// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation select encoding on the op port
//   state_e : sequencer state encoding
//   ITER_LAST : last iteration count value in RUN (32 iterations, 0..31)
//   neg32   : conditional two's-complement negate, used to take operand
//             magnitudes at start and to restore signs at the end
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic [5:0] ITER_LAST = 6'd31;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_add32.sv
// add32: plain 32-bit adder with carry in/out. The iteration datapath of
// muldiv uses one instance for both the multiply accumulate and the
// restoring-divide trial subtraction (a + ~b + 1).
//   a, b : addends
//   cin  : carry in
//   sum  : 32-bit sum
//   cout : carry out
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative MIPS-style HI/LO multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes; signs are restored in a single fix-up cycle.
//
//   state  | meaning
//   IDLE   | waiting for start; MTHI/MTLO writes accepted here only
//   RUN    | 32 iterations, one product/quotient bit per cycle
//   FIX    | sign correction, divide-by-zero override, HI/LO written
//   DONE   | one-cycle done pulse, returns to IDLE
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start, op      : launch an operation (op: MULT/MULTU/DIV/DIVU)
//   a, b           : operands, sampled with start
//   we_hi, we_lo   : direct writes of wdata to HI / LO (IDLE only)
//   wdata          : direct-write data
//   busy           : operation in progress (RUN and FIX)
//   done           : one-cycle pulse when HI/LO hold a new result
//   hi, lo         : architectural HI/LO registers
module muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  state_e      state;
  logic [1:0]  op_q;
  logic [31:0] w_hi;     // partial product high half / running remainder
  logic [31:0] w_lo;     // multiplier shifting out / dividend shifting into quotient
  logic [31:0] m;        // multiplicand or divisor magnitude
  logic [5:0]  cnt;
  logic        neg_a;
  logic        neg_b;
  logic        b_zero;

  logic        is_div;
  logic        start_sa;
  logic        start_sb;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic        trial_ok;

  logic [63:0] prod;
  logic [63:0] prod_neg;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign start_sa = ((op == OP_MULT) || (op == OP_DIV)) && a[31];
  assign start_sb = ((op == OP_MULT) || (op == OP_DIV)) && b[31];

  // Divide feeds the remainder shifted left with the next dividend bit and
  // subtracts the divisor; multiply adds the multiplicand to the high half.
  always_comb begin
    add_a   = w_hi;
    add_b   = m;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {w_hi[30:0], w_lo[31]};
      add_b   = ~m;
      add_cin = 1'b1;
    end
  end

  add32 u_add32 (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    step_hi  = w_hi;
    step_lo  = w_lo;
    trial_ok = 1'b0;
    if (is_div) begin
      // The shifted remainder is 33 bits; its top bit set means it already
      // exceeds any 32-bit divisor, so the subtraction always succeeds.
      trial_ok = w_hi[31] | add_cout;
      step_hi  = trial_ok ? add_sum : add_a;
      step_lo  = {w_lo[30:0], trial_ok};
    end else if (w_lo[0]) begin
      step_hi = {add_cout, add_sum[31:1]};
      step_lo = {add_sum[0], w_lo[31:1]};
    end else begin
      step_hi = {1'b0, w_hi[31:1]};
      step_lo = {w_hi[0], w_lo[31:1]};
    end
  end

  // A zero divisor naturally yields an all-ones quotient and |a| as the
  // remainder; restoring the dividend sign on that remainder gives back a.
  always_comb begin
    prod     = {w_hi, w_lo};
    prod_neg = ~prod + 64'd1;
    fix_hi   = w_hi;
    fix_lo   = w_lo;
    if (is_div) begin
      fix_hi = neg32(w_hi, neg_a);
      fix_lo = b_zero ? 32'hFFFF_FFFF : neg32(w_lo, neg_a ^ neg_b);
    end else if (neg_a ^ neg_b) begin
      fix_hi = prod_neg[63:32];
      fix_lo = prod_neg[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= 2'b00;
      w_hi   <= 32'd0;
      w_lo   <= 32'd0;
      m      <= 32'd0;
      cnt    <= 6'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (we_hi) hi <= wdata;
          if (we_lo) lo <= wdata;
          if (start) begin
            op_q   <= op;
            neg_a  <= start_sa;
            neg_b  <= start_sb;
            b_zero <= (b == '0);
            w_lo   <= neg32(a, start_sa);
            m      <= neg32(b, start_sb);
            w_hi   <= 32'd0;
            cnt    <= 6'd0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          cnt  <= cnt + 6'd1;
          if (cnt == ITER_LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= 6'd0;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
